// File: rtl/gray_seq_ctrl.sv
// Sequencing controller for an external 5-bit Gray counter: clears it, enables it
// for N steps (with pause/abort), and checks its Gray output against a binary shadow.
module gray_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [4:0] steps,
  input  logic [4:0] gray_in,
  output logic       cnt_en,
  output logic       cnt_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] last_gray
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_len;
  logic [5:0] r_step;
  logic [4:0] r_exp_bin;
  logic       r_err;
  logic [4:0] r_last_gray;

  logic       w_accept;
  logic       w_last_step;
  logic       w_check;
  logic [4:0] w_exp_gray;

  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_last_step = cnt_en && ((r_step + 6'd1) == r_len);
  assign w_check     = (r_state == RUN) || (r_state == DONE);
  assign w_exp_gray  = r_exp_bin ^ (r_exp_bin >> 1);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next    = r_state;
    cnt_en    = 1'b0;
    cnt_rst_n = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = CLEAR;
      end
      CLEAR: begin
        cnt_rst_n = 1'b0;
        busy      = 1'b1;
        w_next    = abort ? IDLE : RUN;
      end
      RUN: begin
        busy   = 1'b1;
        cnt_en = !pause;
        if (abort)            w_next = IDLE;
        else if (w_last_step) w_next = DONE;
      end
      DONE: begin
        // An abort in the completion cycle suppresses the pulse and the capture.
        done   = !abort;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_len       <= 6'd32;
      r_step      <= 6'd0;
      r_exp_bin   <= 5'd0;
      r_err       <= 1'b0;
      r_last_gray <= 5'd0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_len  <= (steps == 5'd0) ? 6'd32 : {1'b0, steps};
        r_step <= 6'd0;
      end else if (cnt_en) begin
        r_step <= r_step + 6'd1;
      end

      if (r_state == CLEAR)  r_exp_bin <= 5'd0;
      else if (cnt_en)       r_exp_bin <= r_exp_bin + 5'd1;

      if (w_accept)                                  r_err <= 1'b0;
      else if (w_check && (gray_in != w_exp_gray))   r_err <= 1'b1;

      if (done) r_last_gray <= gray_in;
    end
  end

  assign err       = r_err;
  assign last_gray = r_last_gray;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: an ideal Gray counter with fault injection sits on the
// controller, and each run is predicted from N, the pause pattern and any injected fault.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       pause;
  logic [4:0] steps;
  logic [4:0] gray_in;
  logic       cnt_en;
  logic       cnt_rst_n;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] last_gray;

  int   checks = 0;
  int   errors = 0;

  logic [4:0] cnt = 5'd0;
  bit         inj = 1'b0;
  bit         exp_err = 1'b0;
  int         exp_last = 0;

  gray_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .steps     (steps),
    .gray_in   (gray_in),
    .cnt_en    (cnt_en),
    .cnt_rst_n (cnt_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .last_gray (last_gray)
  );

  always #5 clk = ~clk;

  // Ideal controlled counter: synchronous clear, count on enable.
  always @(posedge clk) begin
    if (!cnt_rst_n)  cnt <= 5'd0;
    else if (cnt_en) cnt <= cnt + 5'd1;
  end

  assign gray_in = {cnt[4], cnt[4]^cnt[3], cnt[3]^cnt[2], cnt[2]^cnt[1], cnt[1]^cnt[0]}
                   ^ {4'b0000, inj};

  function automatic int gray_of(input int b);
    int g;
    g = 0;
    g[4] = b[4];
    for (int i = 0; i < 4; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One run: pmode 0 = no pause, 1 = random pause, 2 = pause 3 cycles after 2nd step.
  task automatic run(input int s, input int pmode, input int inj_at, input int abort_at,
                     input bit mid_start, input bit start_in_done);
    int n;
    int en_cnt;
    int k;
    int phold;
    bit aborted;
    n = (s == 0) ? 32 : s;

    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; steps = 5'(s); pause = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_en", int'(cnt_en), 0);
    exp_err = 1'b0;

    @(posedge clk); #1;
    start = 1'b0; steps = 5'($urandom); pause = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("clr_busy", int'(busy), 1);
    check("clr_rst_n", int'(cnt_rst_n), 0);
    check("clr_en", int'(cnt_en), 0);
    check("clr_err", int'(err), 0);

    en_cnt = 0; k = 0; phold = 0; aborted = 1'b0;
    while (en_cnt < n && !aborted) begin
      @(posedge clk); #1;
      k++;
      case (pmode)
        1:       pause = (k < 100) && ($urandom_range(0, 3) == 0);
        2:       pause = (en_cnt == 2) && (phold < 3);
        default: pause = 1'b0;
      endcase
      inj   = (en_cnt == inj_at);
      abort = (en_cnt == abort_at);
      start = mid_start && (en_cnt == 1);
      steps = 5'($urandom);
      @(negedge clk);
      check("run_busy", int'(busy), 1);
      check("run_en", int'(cnt_en), int'(!pause));
      check("run_rst_n", int'(cnt_rst_n), 1);
      check("run_done", int'(done), 0);
      check("run_err", int'(err), int'(exp_err));
      if (inj) exp_err = 1'b1;
      if (abort) aborted = 1'b1;
      if (!pause) en_cnt++;
      else        phold++;
    end

    @(posedge clk); #1;
    abort = 1'b0; inj = 1'b0; start = start_in_done && !aborted;
    pause = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (aborted) begin
      check("abt_busy", int'(busy), 0);
      check("abt_done", int'(done), 0);
    end else begin
      check("done_pulse", int'(done), 1);
      check("done_busy", int'(busy), 0);
      exp_last = gray_of(n % 32);
    end
    check("post_en", int'(cnt_en), 0);
    check("post_err", int'(err), int'(exp_err));

    @(posedge clk); #1;
    start = 1'b0; pause = 1'b0;
    @(negedge clk);
    check("idle_done", int'(done), 0);
    check("idle_busy2", int'(busy), 0);
    check("last_gray", int'(last_gray), exp_last);
    check("idle_err", int'(err), int'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; steps = 5'd0;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_en", int'(cnt_en), 0);
    check("rst_rst_n", int'(cnt_rst_n), 1);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_last", int'(last_gray), 0);
    @(negedge clk);
    reset = 1'b0;

    run(5, 0, -1, -1, 1'b0, 1'b0);
    run(0, 0, -1, -1, 1'b0, 1'b0);
    run(4, 2, -1, -1, 1'b0, 1'b0);
    run(8, 0, 3, -1, 1'b0, 1'b0);
    run(10, 0, -1, 4, 1'b0, 1'b0);
    run(2, 0, -1, -1, 1'b1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      int s;
      int ia;
      s  = $urandom_range(0, 31);
      ia = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ((s == 0) ? 32 : s) - 1) : -1;
      run(s, 1, ia, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort together with start in IDLE: start must be ignored.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; steps = 5'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abst_busy", int'(busy), 0);
    check("abst_rst_n", int'(cnt_rst_n), 1);
    check("abst_err", int'(err), int'(exp_err));

    // Asynchronous reset in the middle of a RUN cycle with err set.
    @(posedge clk); #1;
    start = 1'b1; steps = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    check("pre_rst_err", int'(err), 1);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_en", int'(cnt_en), 0);
    check("mid_rst_rst_n", int'(cnt_rst_n), 1);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_last", int'(last_gray), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_err = 1'b0; exp_last = 0;

    run(3, 1, -1, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
